demux3_stream: RTL and testbench

- 1-to-3 streaming demultiplexer with valid/ready handshake; the write-side counterpart to the 3:1 select mux in the LBM datapath.
- Steers one signed DATA_WIDTH word per accepted transfer to lane 0, 1 or 2 according to a 2-bit select.
- Each lane has a one-entry registered output buffer, so downstream stages (collision/streaming units) can stall independently.

---
 rtl/demux3_stream.sv | 85 ++++++++
 tb/tb_demux3_stream.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/demux3_stream.sv
// 1-to-3 streaming demultiplexer with a one-entry registered buffer per lane.
// Optional per-lane transfer counters are enabled by defining DEMUX3_CNT_EN.
module demux3_stream #(
    parameter int DATA_WIDTH = 64
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic signed [DATA_WIDTH-1:0] Din,
    input  logic        [1:0]            select,
    output logic signed [DATA_WIDTH-1:0] Dout0,
    output logic signed [DATA_WIDTH-1:0] Dout1,
    output logic signed [DATA_WIDTH-1:0] Dout2,
    output logic        [2:0]            out_valid,
    input  logic        [2:0]            out_ready
`ifdef DEMUX3_CNT_EN
    ,
    output logic        [15:0]           cnt0,
    output logic        [15:0]           cnt1,
    output logic        [15:0]           cnt2
`endif
);

    // Code 11 aliases lane 2, matching the default arm of the companion mux.
    function automatic logic [1:0] lane_of(input logic [1:0] sel);
        return (sel == 2'b11) ? 2'd2 : sel;
    endfunction

    logic signed [DATA_WIDTH-1:0] r_dout [3];
    logic        [2:0]            r_valid;
    logic        [1:0]            w_lane;
    logic        [2:0]            w_load;
    logic        [2:0]            w_drain;
    logic                         w_ready;

    always_comb begin
        w_lane  = lane_of(select);
        w_ready = !r_valid[w_lane] || out_ready[w_lane];
        w_load  = 3'b000;
        if (in_valid && w_ready)
            w_load[w_lane] = 1'b1;
        w_drain = r_valid & out_ready;
    end

    // Stage boundary: input word lands in its lane buffer on the next edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_valid <= 3'b000;
            for (int i = 0; i < 3; i++)
                r_dout[i] <= '0;
        end else begin
            r_valid <= (r_valid & ~w_drain) | w_load;
            for (int i = 0; i < 3; i++)
                if (w_load[i])
                    r_dout[i] <= Din;
        end
    end

`ifdef DEMUX3_CNT_EN
    logic [15:0] r_cnt [3];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 3; i++)
                r_cnt[i] <= '0;
        end else begin
            for (int i = 0; i < 3; i++)
                if (w_load[i])
                    r_cnt[i] <= r_cnt[i] + 16'd1;
        end
    end

    assign cnt0 = r_cnt[0];
    assign cnt1 = r_cnt[1];
    assign cnt2 = r_cnt[2];
`endif

    assign in_ready  = w_ready;
    assign out_valid = r_valid;
    assign Dout0     = r_dout[0];
    assign Dout1     = r_dout[1];
    assign Dout2     = r_dout[2];

endmodule

// File: tb/tb_demux3_stream.sv
// Directed scoreboard bench for demux3_stream; counter checks run when DEMUX3_CNT_EN is defined.
module tb_demux3_stream;

    localparam int DW = 64;

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 in_valid;
    logic                 in_ready;
    logic signed [DW-1:0] Din;
    logic        [1:0]    select;
    logic signed [DW-1:0] Dout0;
    logic signed [DW-1:0] Dout1;
    logic signed [DW-1:0] Dout2;
    logic        [2:0]    out_valid;
    logic        [2:0]    out_ready;
`ifdef DEMUX3_CNT_EN
    logic        [15:0]   cnt0;
    logic        [15:0]   cnt1;
    logic        [15:0]   cnt2;
`endif

    int n_checks = 0;
    int n_fails  = 0;

    logic signed [DW-1:0] q0 [$];
    logic signed [DW-1:0] q1 [$];
    logic signed [DW-1:0] q2 [$];

    always #5 clk = ~clk;

    demux3_stream #(.DATA_WIDTH(DW)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .Din       (Din),
        .select    (select),
        .Dout0     (Dout0),
        .Dout1     (Dout1),
        .Dout2     (Dout2),
        .out_valid (out_valid),
        .out_ready (out_ready)
`ifdef DEMUX3_CNT_EN
        ,
        .cnt0      (cnt0),
        .cnt1      (cnt1),
        .cnt2      (cnt2)
`endif
    );

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_lanes();
        chk("out_valid", {61'd0, out_valid}, {61'd0, q2.size() != 0, q1.size() != 0, q0.size() != 0});
        if (q0.size() != 0) chk("Dout0", Dout0, q0[0]);
        if (q1.size() != 0) chk("Dout1", Dout1, q1[0]);
        if (q2.size() != 0) chk("Dout2", Dout2, q2[0]);
    endtask

    // Called #1 after a rising edge; drives one cycle and checks after the next edge.
    task automatic cycle(input logic v, input logic signed [DW-1:0] d, input logic [1:0] s,
                         input logic [2:0] ordy, input logic exp_rdy);
        in_valid  = v;
        Din       = d;
        select    = s;
        out_ready = ordy;
        #1;
        chk("in_ready", {63'd0, in_ready}, {63'd0, exp_rdy});
        if (ordy[0] && q0.size() != 0) begin chk("drain0", Dout0, q0[0]); q0.delete(0); end
        if (ordy[1] && q1.size() != 0) begin chk("drain1", Dout1, q1[0]); q1.delete(0); end
        if (ordy[2] && q2.size() != 0) begin chk("drain2", Dout2, q2[0]); q2.delete(0); end
        if (v && exp_rdy) begin
            if (s == 2'b00)      q0.push_back(d);
            else if (s == 2'b01) q1.push_back(d);
            else                 q2.push_back(d);
        end
        @(posedge clk);
        #1;
        check_lanes();
    endtask

    task automatic idle(input logic [2:0] ordy);
        cycle(1'b0, '0, 2'b00, ordy, 1'b1);
    endtask

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        Din       = '0;
        select    = 2'b00;
        out_ready = 3'b000;
        #1;
        chk("rst_valid", {61'd0, out_valid}, 64'd0);
        chk("rst_ready", {63'd0, in_ready}, 64'd1);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Fill all lanes, then reset asynchronously between edges.
        cycle(1'b1, 64'sd1, 2'b00, 3'b000, 1'b1);
        cycle(1'b1, 64'sd2, 2'b01, 3'b000, 1'b1);
        cycle(1'b1, 64'sd3, 2'b10, 3'b000, 1'b1);
        chk("full_valid", {61'd0, out_valid}, 64'd7);
        #2;
        reset = 1'b1;
        #1;
        chk("arst_valid", {61'd0, out_valid}, 64'd0);
        chk("arst_dout0", Dout0, 64'd0);
        chk("arst_dout1", Dout1, 64'd0);
        chk("arst_dout2", Dout2, 64'd0);
        q0.delete(); q1.delete(); q2.delete();
        @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        chk("post_rst_ready", {63'd0, in_ready}, 64'd1);
        @(posedge clk);
        #1;

        // Routing, including sign preservation and the 11 alias.
        cycle(1'b1, -64'sd5, 2'b00, 3'b111, 1'b1);
        cycle(1'b1, 64'sh7FFF_FFFF_FFFF_FFFF, 2'b01, 3'b111, 1'b1);
        cycle(1'b1, 64'sd42, 2'b10, 3'b111, 1'b1);
        cycle(1'b1, -64'sd1, 2'b11, 3'b111, 1'b1);
        chk("alias_dout2", Dout2, 64'hFFFF_FFFF_FFFF_FFFF);
        idle(3'b111);

        // Stall on lane 1, then release with simultaneous drain and load.
        cycle(1'b1, 64'sd10, 2'b01, 3'b101, 1'b1);
        cycle(1'b1, 64'sd20, 2'b01, 3'b101, 1'b0);
        cycle(1'b1, 64'sd20, 2'b01, 3'b101, 1'b0);
        chk("stall_hold", Dout1, 64'd10);
        cycle(1'b1, 64'sd20, 2'b01, 3'b111, 1'b1);
        chk("no_bubble_v1", {63'd0, out_valid[1]}, 64'd1);
        chk("no_bubble_d1", Dout1, 64'd20);
        idle(3'b111);

        // Back-to-back throughput into lane 2.
        for (int i = 0; i < 100; i++)
            cycle(1'b1, 64'(i * 3 - 50), 2'b10, 3'b111, 1'b1);
        idle(3'b111);

        // Lane 0 stalled while lane 2 keeps flowing.
        cycle(1'b1, 64'sd7, 2'b00, 3'b110, 1'b1);
        cycle(1'b1, 64'sd8, 2'b10, 3'b110, 1'b1);
        chk("indep_dout0", Dout0, 64'd7);
        cycle(1'b1, 64'sd9, 2'b00, 3'b110, 1'b0);
        idle(3'b111);

`ifdef DEMUX3_CNT_EN
        #2;
        reset = 1'b1;
        #1;
        q0.delete(); q1.delete(); q2.delete();
        chk("cnt_rst0", {48'd0, cnt0}, 64'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        for (int i = 0; i < 65537; i++)
            cycle(1'b1, 64'(i), 2'b01, 3'b111, 1'b1);
        chk("cnt0", {48'd0, cnt0}, 64'd0);
        chk("cnt1", {48'd0, cnt1}, 64'd1);
        chk("cnt2", {48'd0, cnt2}, 64'd0);
        #2;
        reset = 1'b1;
        #1;
        chk("cnt1_rst", {48'd0, cnt1}, 64'd0);
        chk("cnt_all_rst", {16'd0, cnt0, cnt1, cnt2}, 64'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
